// File: rtl/alu_operand_loader.sv
// ALU operand front end: one debounced load button steps a sequencer
// that captures operand A, operand B and the opcode from the switch bus.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic        btn,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  op,
    output logic [1:0]  stage,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic              stable;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       data_q;
    logic              differ;
    logic              settle;
    logic              press;

    assign differ = (sync2 != stable);
    assign settle = differ && (cnt == CNT_MAX);
    // Capture on the same edge that the debounced level rises.
    assign press  = settle && sync2;
    assign stage  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            data_q <= data;
            if (!differ) begin
                cnt <= '0;
            end else if (settle) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            operand_a <= '0;
            operand_b <= '0;
            op        <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (press) begin
                unique case (state)
                    S_A: begin
                        operand_a <= data_q;
                        state     <= S_B;
                    end
                    S_B: begin
                        operand_b <= data_q;
                        state     <= S_OP;
                    end
                    S_OP: begin
                        op    <= data_q[31:28];
                        valid <= 1'b1;
                        state <= S_SHOW;
                    end
                    S_SHOW: begin
                        operand_a <= data_q;
                        state     <= S_B;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed press table, multi-cycle
// corner sequences and random button runs against a press-count model.
module tb_alu_operand_loader;

    localparam int D = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        btn;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  op;
    logic [1:0]  stage;
    logic        valid;

    alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .btn       (btn),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .stage     (stage),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: btn seen two edges late, data one edge late,
    // level changes after D consecutive disagreeing samples, and the
    // outputs follow from how many presses have been counted.
    logic        m_b1, m_b2;
    logic [31:0] m_d;
    logic        m_level;
    int          m_run;
    int          m_presses;
    logic [31:0] m_a, m_bop;
    logic [3:0]  m_op;
    logic        m_valid;

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_d = 0; m_level = 0; m_run = 0;
        m_presses = 0; m_a = 0; m_bop = 0; m_op = 0; m_valid = 0;
    endtask

    function automatic logic [1:0] m_stage();
        if (m_presses == 0) return 2'd0;
        return 2'((m_presses - 1) % 3 + 1);
    endfunction

    task automatic model_step(input logic b, input logic [31:0] d);
        logic seen;
        logic pressed;
        seen    = m_b2;
        pressed = 0;
        m_valid = 0;
        if (seen != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = seen;
                m_run   = 0;
                pressed = seen;
            end
        end else begin
            m_run = 0;
        end
        if (pressed) begin
            case (m_presses % 3)
                0: m_a = m_d;
                1: m_bop = m_d;
                default: begin
                    m_op    = m_d[31:28];
                    m_valid = 1;
                end
            endcase
            m_presses++;
        end
        m_b2 = m_b1;
        m_b1 = b;
        m_d  = d;
    endtask

    task automatic tick();
        logic        b;
        logic [31:0] d;
        b = btn;
        d = data;
        @(posedge clk);
        if (rst_n) model_step(b, d);
        #1;
        chk("model", {operand_a, operand_b, op, stage, valid},
            {m_a, m_bop, m_op, m_stage(), m_valid});
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        model_reset();
        tick();
        tick();
        #2;
        rst_n = 1;
    endtask

    task automatic press(input logic [31:0] d, input int hi, input int lo,
                         output int nvalid);
        nvalid = 0;
        data = d;
        btn  = 1;
        repeat (hi) begin
            tick();
            if (valid) nvalid++;
        end
        btn = 0;
        repeat (lo) begin
            tick();
            if (valid) nvalid++;
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  o;
        logic [1:0]  st;
        int          nv;
    } vec_t;

    vec_t vt[4];

    initial begin
        int nv, cap, nch;
        logic [1:0] prev;
        logic lvl;
        int run;

        vt[0] = '{32'h0000_0005, 32'd5, 32'd0, 4'd0, 2'd1, 0};
        vt[1] = '{32'h0000_0007, 32'd5, 32'd7, 4'd0, 2'd2, 0};
        vt[2] = '{32'h2000_0000, 32'd5, 32'd7, 4'd2, 2'd3, 1};
        vt[3] = '{32'h0000_0009, 32'd9, 32'd7, 4'd2, 2'd1, 0};

        rst_n = 0;
        btn   = 0;
        data  = 0;
        model_reset();
        #3;
        chk("rst_a", 72'(operand_a), 72'(0));
        chk("rst_b", 72'(operand_b), 72'(0));
        chk("rst_op", 72'(op), 72'(0));
        chk("rst_stage", 72'(stage), 72'(0));
        chk("rst_valid", 72'(valid), 72'(0));
        #10;
        rst_n = 1;

        // Clean presses, then a restart from S_SHOW.
        for (int i = 0; i < 4; i++) begin
            press(vt[i].d, 10, 10, nv);
            chk($sformatf("tbl%0d_a", i), 72'(operand_a), 72'(vt[i].a));
            chk($sformatf("tbl%0d_b", i), 72'(operand_b), 72'(vt[i].b));
            chk($sformatf("tbl%0d_op", i), 72'(op), 72'(vt[i].o));
            chk($sformatf("tbl%0d_stage", i), 72'(stage), 72'(vt[i].st));
            chk($sformatf("tbl%0d_valid", i), 72'(nv), 72'(vt[i].nv));
        end

        // Press latency.
        do_reset();
        data = 32'hDEAD_BEEF;
        btn  = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) chk("lat_early", 72'(operand_a), 72'(0));
            if (i == 6) begin
                chk("lat_a", 72'(operand_a), 72'(32'hDEAD_BEEF));
                chk("lat_stage", 72'(stage), 72'(1));
            end
        end
        repeat (4) tick();
        btn = 0;
        repeat (10) tick();

        // Bounce then hold.
        data = 32'hB0B0_0001;
        repeat (5) begin
            btn = 1;
            repeat (3) tick();
            btn = 0;
            tick();
        end
        chk("bounce_none", 72'(operand_b), 72'(0));
        btn = 1;
        cap = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cap == 0 && operand_b != 0) cap = i;
        end
        chk("bounce_at", 72'(cap), 72'(6));
        chk("bounce_stage", 72'(stage), 72'(2));
        btn = 0;
        repeat (10) tick();

        // Long hold with a bouncy release.
        data = 32'h3000_0000;
        btn  = 1;
        nch  = 0;
        nv   = 0;
        prev = stage;
        for (int i = 0; i < 240; i++) begin
            if (i == 200) btn = 0;
            if (i >= 202 && i < 218) btn = ((i - 202) % 4) < 2;
            if (i == 218) btn = 0;
            tick();
            if (stage != prev) nch++;
            prev = stage;
            if (valid) nv++;
        end
        chk("hold_changes", 72'(nch), 72'(1));
        chk("hold_valid", 72'(nv), 72'(1));
        chk("hold_stage", 72'(stage), 72'(3));
        chk("hold_op", 72'(op), 72'(3));

        // Asynchronous reset in S_OP with a debounce in flight.
        do_reset();
        press(32'h1, 10, 10, nv);
        press(32'h2, 10, 10, nv);
        chk("mid_stage", 72'(stage), 72'(2));
        data = 32'h0000_00C3;
        btn  = 1;
        repeat (4) tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_rst", {operand_a, operand_b, op, stage, valid}, 72'(0));
        #2;
        rst_n = 1;
        cap = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cap == 0 && operand_a != 0) cap = i;
        end
        chk("rst_cap_at", 72'(cap), 72'(D + 2));
        chk("rst_cap_a", 72'(operand_a), 72'(32'hC3));
        chk("rst_cap_stage", 72'(stage), 72'(1));
        btn = 0;
        repeat (10) tick();

        // Random button runs and switch values.
        lvl = 0;
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if (run == 0) begin
                lvl = ~lvl;
                run = $urandom_range(1, 12);
            end
            run--;
            btn  = lvl;
            data = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
